// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the programmable clock divider.
package clkdiv_pkg;

   localparam int unsigned CNT_W  = 18;
   localparam int unsigned MAX_CH = 8;
   localparam int unsigned CH_W   = $clog2(MAX_CH);

   typedef logic [CNT_W-1:0] div_t;

   // Reset divisors for a 100 MHz system clock.
   localparam div_t DEFAULT_DIV_1KHZ  = div_t'(100000);
   localparam div_t DEFAULT_DIV_500HZ = div_t'(200000);

endpackage

// File: rtl/prog_clock_divider_if.sv
// Divisor configuration bus: write strobe, target channel, divisor and status back.
interface prog_clock_divider_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 18
);
   import clkdiv_pkg::*;

   logic                cfg_valid;
   logic                cfg_ready;
   logic [CH_W-1:0]     cfg_ch;
   logic [CNT_W-1:0]    cfg_div;
   logic                cfg_err;
   logic [NUM_CH-1:0]   cfg_pending;

   modport master (
      output cfg_valid, cfg_ch, cfg_div,
      input  cfg_ready, cfg_err, cfg_pending
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div,
      output cfg_ready, cfg_err, cfg_pending
   );

endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, shadow divisor and registered clk_out/tick.
module clkdiv_channel #(
   parameter int unsigned      CNT_W   = 18,
   parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(100000)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);

   logic [CNT_W-1:0] n_q, n_d, ctr_q, ctr_d, pdiv_q, pdiv_d, high_len;
   logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
   logic             wrap, apply;

   always_comb begin
      wrap  = en && (ctr_q >= n_q - CNT_W'(1));
      // A shadow divisor takes effect on any period boundary, or at once while idle.
      apply = pend_q && (!en || wrap || sync);

      n_d    = apply ? pdiv_q : n_q;
      pend_d = pend_q && !apply;
      pdiv_d = pdiv_q;
      if (wr) begin
         pend_d = 1'b1;
         pdiv_d = wr_div;
      end

      if (!en || sync || wrap) begin
         ctr_d = '0;
      end else begin
         ctr_d = ctr_q + CNT_W'(1);
      end

      // Odd divisors spend the extra cycle in the high phase.
      high_len = n_d - (n_d >> 1);
      clk_d    = !en || (ctr_d < high_len);
      tick_d   = wrap && !sync;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         n_q    <= DEF_DIV;
         ctr_q  <= '0;
         pdiv_q <= DEF_DIV;
         pend_q <= 1'b0;
         clk_q  <= 1'b1;
         tick_q <= 1'b0;
      end else begin
         n_q    <= n_d;
         ctr_q  <= ctr_d;
         pdiv_q <= pdiv_d;
         pend_q <= pend_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign pending = pend_q;
   assign clk_out = clk_q;
   assign tick    = tick_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: config decode plus NUM_CH divider channels.
module prog_clock_divider #(
   parameter int unsigned             NUM_CH      = 2,
   parameter int unsigned             CNT_W       = clkdiv_pkg::CNT_W,
   parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIV = {clkdiv_pkg::DEFAULT_DIV_500HZ,
                                                     clkdiv_pkg::DEFAULT_DIV_1KHZ}
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    en,
   input  logic                 sync,
   prog_clock_divider_if.slave  cfg,
   output logic [NUM_CH-1:0]    clk_out,
   output logic [NUM_CH-1:0]    tick
);
   import clkdiv_pkg::*;

   localparam logic [CH_W:0] NumChW = (CH_W+1)'(NUM_CH);

   logic              cfg_ok;
   logic              cfg_err_q;
   logic [NUM_CH-1:0] wr;
   logic [NUM_CH-1:0] pend;

   assign cfg_ok = cfg.cfg_valid && (cfg.cfg_div >= CNT_W'(2)) && ({1'b0, cfg.cfg_ch} < NumChW);

   always_comb begin
      wr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr[i] = cfg_ok && (cfg.cfg_ch == CH_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg.cfg_valid && !cfg_ok;
      end
   end

   assign cfg.cfg_err     = cfg_err_q;
   assign cfg.cfg_ready   = 1'b1;
   assign cfg.cfg_pending = pend;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clkdiv_channel #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEFAULT_DIV[i*CNT_W +: CNT_W])
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .en      (en[i]),
         .sync    (sync),
         .wr      (wr[i]),
         .wr_div  (cfg.cfg_div),
         .pending (pend[i]),
         .clk_out (clk_out[i]),
         .tick    (tick[i])
      );
   end

endmodule
